// File: rtl/vga_timing_pkg.sv
// Shared timing constants for the 640x480 @ 60 Hz raster generator.
// Holds the default porch/sync/active values, the derived totals, the sync
// window bounds and a small window-decode helper used by the top level.
package vga_timing_pkg;

  // Counter and output widths
  localparam int unsigned CNT_W  = 10;
  localparam int unsigned Y_W    = 9;
  localparam int unsigned FCTR_W = 10;

  // Default horizontal timing (pixels)
  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FP     = 16;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BP     = 48;

  // Default vertical timing (lines)
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FP     = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BP     = 33;

  // Derived totals for the default mode
  localparam int unsigned H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int unsigned V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  // Sync windows for the default mode, [START, END)
  localparam int unsigned H_SYNC_START = DEF_H_ACTIVE + DEF_H_FP;
  localparam int unsigned H_SYNC_END   = H_SYNC_START + DEF_H_SYNC;
  localparam int unsigned V_SYNC_START = DEF_V_ACTIVE + DEF_V_FP;
  localparam int unsigned V_SYNC_END   = V_SYNC_START + DEF_V_SYNC;

  // True when cnt lies in the half-open window [lo, hi)
  function automatic logic in_window(input logic [CNT_W-1:0] cnt,
                                     input int unsigned      lo,
                                     input int unsigned      hi);
    return (cnt >= CNT_W'(lo)) && (cnt < CNT_W'(hi));
  endfunction

endpackage

// File: rtl/vga_timing_gen_wrap_counter.sv
// wrap_counter: up-counter with enable, synchronous active-low reset and a
// terminal value MAX after which it returns to zero.
// Ports:
//   clk, rst_n    clock, synchronous active-low reset
//   en_i          advance enable
//   cnt_o         current count (registered)
//   cnt_nxt_c_o   value the count takes at the next edge (ignores reset)
//   wrap_c_o      high when enabled and at MAX, i.e. wrapping this edge
module wrap_counter #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned MAX   = 799
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  output logic [WIDTH-1:0] cnt_o,
  output logic [WIDTH-1:0] cnt_nxt_c_o,
  output logic             wrap_c_o
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;
  logic             at_max_c;

  assign at_max_c = (cnt_q == WIDTH'(MAX));

  // Next count
  always_comb begin
    cnt_d = cnt_q;
    if (en_i) begin
      cnt_d = at_max_c ? '0 : cnt_q + WIDTH'(1);
    end
  end

  // Count register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o       = cnt_q;
  assign cnt_nxt_c_o = cnt_d;
  assign wrap_c_o    = en_i & at_max_c;

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: pixel-timing generator (default 640x480 @ 60 Hz).
// Produces raster coordinates, the active-area qualifier and active-low sync
// pulses. All qualifiers are registered from the next-state counter values so
// they change on the same edge as x/y (vsync is glitch-free).
// Optional build macro: VGA_TIMING_FRAME_CTR_EN builds the frame counter;
// without it frame_ctr is tied to zero. The port list is the same either way.
// Ports:
//   clk           pixel clock, or 2x pixel clock qualified by ce
//   rst_n         synchronous active-low reset (overrides ce)
//   ce            pixel advance enable
//   x             horizontal position 0..H_TOTAL-1
//   y             vertical position, low 9 bits (aliases above line 511)
//   frame_active  high inside the visible area
//   hsync, vsync  active-low sync pulses
//   frame_start   high for the ce-qualified cycle at (0,0)
//   frame_ctr     frames seen (counts vsync falling edges), or 0
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ce,
  output logic [CNT_W-1:0]  x,
  output logic [Y_W-1:0]    y,
  output logic              frame_active,
  output logic              hsync,
  output logic              vsync,
  output logic              frame_start,
  output logic [FCTR_W-1:0] frame_ctr
);

  localparam int unsigned H_TOT    = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOT    = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_START = H_ACTIVE + H_FP;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_ACTIVE + V_FP;
  localparam int unsigned VS_END   = VS_START + V_SYNC;

  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] h_nxt;
  logic [CNT_W-1:0] v_cnt;
  logic [CNT_W-1:0] v_nxt;
  logic             h_wrap;
  logic             v_en;
  logic             v_wrap_unused;

  assign v_en = ce & h_wrap;

  // Horizontal position
  wrap_counter #(
    .WIDTH (CNT_W),
    .MAX   (H_TOT - 1)
  ) u_h_cnt (
    .clk         (clk),
    .rst_n       (rst_n),
    .en_i        (ce),
    .cnt_o       (h_cnt),
    .cnt_nxt_c_o (h_nxt),
    .wrap_c_o    (h_wrap)
  );

  // Vertical position, advances when the line wraps
  wrap_counter #(
    .WIDTH (CNT_W),
    .MAX   (V_TOT - 1)
  ) u_v_cnt (
    .clk         (clk),
    .rst_n       (rst_n),
    .en_i        (v_en),
    .cnt_o       (v_cnt),
    .cnt_nxt_c_o (v_nxt),
    .wrap_c_o    (v_wrap_unused)
  );

  logic hsync_q,  hsync_d;
  logic vsync_q,  vsync_d;
  logic active_q, active_d;
  logic origin_q, origin_d;

  // Qualifiers decoded from the next position so they line up with x/y
  always_comb begin
    hsync_d  = ~in_window(h_nxt, HS_START, HS_END);
    vsync_d  = ~in_window(v_nxt, VS_START, VS_END);
    active_d = (h_nxt < CNT_W'(H_ACTIVE)) && (v_nxt < CNT_W'(V_ACTIVE));
    origin_d = (h_nxt == '0) && (v_nxt == '0);
  end

  // Reset values match the decode of position (0,0)
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hsync_q  <= 1'b1;
      vsync_q  <= 1'b1;
      active_q <= 1'b1;
      origin_q <= 1'b1;
    end else begin
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      active_q <= active_d;
      origin_q <= origin_d;
    end
  end

  assign x            = h_cnt;
  assign y            = v_cnt[Y_W-1:0];
  assign hsync        = hsync_q;
  assign vsync        = vsync_q;
  assign frame_active = active_q;
  // Qualified by ce so a held (0,0) on a 2x clock reports only one start
  assign frame_start  = origin_q & ce & rst_n;

  logic [CNT_W-Y_W-1:0] unused_v_msb;
  assign unused_v_msb = v_cnt[CNT_W-1:Y_W];

`ifdef VGA_TIMING_FRAME_CTR_EN
  logic [FCTR_W-1:0] fctr_q;
  logic [FCTR_W-1:0] fctr_d;

  // Count on the edge that enters the first vsync line
  always_comb begin
    fctr_d = fctr_q;
    if (v_en && (v_cnt == CNT_W'(VS_START - 1))) begin
      fctr_d = fctr_q + FCTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fctr_q <= '0;
    end else begin
      fctr_q <= fctr_d;
    end
  end

  assign frame_ctr = fctr_q;
`else
  assign frame_ctr = '0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three instances (default 640x480, a narrow-line
// variant with the real vertical timing, and a tiny 4x4 raster) driven by the
// same inputs and compared every cycle against a pixel-index model.
module tb_vga_timing_gen;
  import vga_timing_pkg::*;

`ifdef VGA_TIMING_FRAME_CTR_EN
  localparam bit CTR_EN = 1'b1;
`else
  localparam bit CTR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic ce;

  logic [9:0] xo  [3];
  logic [8:0] yo  [3];
  logic       fao [3];
  logic       hso [3];
  logic       vso [3];
  logic       fso [3];
  logic [9:0] fco [3];

  vga_timing_gen dut0 (
    .clk(clk), .rst_n(rst_n), .ce(ce), .x(xo[0]), .y(yo[0]),
    .frame_active(fao[0]), .hsync(hso[0]), .vsync(vso[0]),
    .frame_start(fso[0]), .frame_ctr(fco[0])
  );

  vga_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .ce(ce), .x(xo[1]), .y(yo[1]),
    .frame_active(fao[1]), .hsync(hso[1]), .vsync(vso[1]),
    .frame_start(fso[1]), .frame_ctr(fco[1])
  );

  vga_timing_gen #(
    .H_ACTIVE(1), .H_FP(1), .H_SYNC(1), .H_BP(1),
    .V_ACTIVE(1), .V_FP(1), .V_SYNC(1), .V_BP(1)
  ) dut2 (
    .clk(clk), .rst_n(rst_n), .ce(ce), .x(xo[2]), .y(yo[2]),
    .frame_active(fao[2]), .hsync(hso[2]), .vsync(vso[2]),
    .frame_start(fso[2]), .frame_ctr(fco[2])
  );

  typedef struct packed {
    logic [9:0] x;
    logic [8:0] y;
    logic       fa;
    logic       hs;
    logic       vs;
    logic       fs;
    logic [9:0] fc;
  } obs_t;

  typedef struct packed {
    logic       r;
    logic       c;
    logic [9:0] x;
    logic [8:0] y;
    logic       fa;
    logic       hs;
    logic       vs;
    logic       fs;
  } vec_t;

  // Model timing per instance
  int unsigned m_ha [3] = '{640, 4, 1};
  int unsigned m_hf [3] = '{16, 1, 1};
  int unsigned m_hs [3] = '{96, 2, 1};
  int unsigned m_hb [3] = '{48, 1, 1};
  int unsigned m_va [3] = '{480, 480, 1};
  int unsigned m_vf [3] = '{10, 10, 1};
  int unsigned m_vs [3] = '{2, 2, 1};
  int unsigned m_vb [3] = '{33, 33, 1};

  // Model state: pixel index within the frame and frames counted
  int unsigned mp  [3];
  int unsigned mfr [3];

  int n_chk  = 0;
  int n_pass = 0;
  bit model_on = 1'b0;
  bit cur_r, cur_c;

  function automatic obs_t model_obs(int k, bit r, bit c);
    obs_t o;
    int unsigned ht, h, v;
    ht  = m_ha[k] + m_hf[k] + m_hs[k] + m_hb[k];
    h   = mp[k] % ht;
    v   = mp[k] / ht;
    o.x  = 10'(h);
    o.y  = 9'(v);
    o.fa = (h < m_ha[k]) && (v < m_va[k]);
    o.hs = !((h >= m_ha[k] + m_hf[k]) && (h < m_ha[k] + m_hf[k] + m_hs[k]));
    o.vs = !((v >= m_va[k] + m_vf[k]) && (v < m_va[k] + m_vf[k] + m_vs[k]));
    o.fs = r && c && (mp[k] == 0);
    o.fc = CTR_EN ? 10'(mfr[k]) : 10'd0;
    return o;
  endfunction

  function automatic obs_t act_obs(int k);
    obs_t o;
    o.x  = xo[k];
    o.y  = yo[k];
    o.fa = fao[k];
    o.hs = hso[k];
    o.vs = vso[k];
    o.fs = fso[k];
    o.fc = fco[k];
    return o;
  endfunction

  function automatic vec_t mkv(bit r, bit c, int x, int y, bit fa, bit hs, bit vs, bit fs);
    vec_t v;
    v.r = r; v.c = c; v.x = 10'(x); v.y = 9'(y);
    v.fa = fa; v.hs = hs; v.vs = vs; v.fs = fs;
    return v;
  endfunction

  task automatic check(string name, obs_t act, obs_t exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got x=%0d y=%0d fa=%b hs=%b vs=%b fs=%b fc=%0d, expected x=%0d y=%0d fa=%b hs=%b vs=%b fs=%b fc=%0d",
                  name, act.x, act.y, act.fa, act.hs, act.vs, act.fs, act.fc,
                  exp.x, exp.y, exp.fa, exp.hs, exp.vs, exp.fs, exp.fc);
  endtask

  task automatic check_int(string name, int act, int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic model_step(bit r, bit c);
    for (int k = 0; k < 3; k++) begin
      int unsigned ht, vt;
      ht = m_ha[k] + m_hf[k] + m_hs[k] + m_hb[k];
      vt = m_va[k] + m_vf[k] + m_vs[k] + m_vb[k];
      if (!r) begin
        mp[k]  = 0;
        mfr[k] = 0;
      end else if (c) begin
        mp[k] = (mp[k] + 1) % (ht * vt);
        if (mp[k] == (m_va[k] + m_vf[k]) * ht) mfr[k] = (mfr[k] + 1) % 1024;
      end
    end
  endtask

  // Apply inputs away from the active edge, then compare against the model
  task automatic drive(bit r, bit c);
    @(negedge clk);
    rst_n = r;
    ce    = c;
    cur_r = r;
    cur_c = c;
    #1;
    if (model_on) begin
      for (int k = 0; k < 3; k++) check($sformatf("model_dut%0d", k), act_obs(k), model_obs(k, r, c));
    end
  endtask

  task automatic clk_edge();
    @(posedge clk);
    model_step(cur_r, cur_c);
  endtask

  task automatic cyc(bit r, bit c);
    drive(r, c);
    clk_edge();
  endtask

  vec_t tbl [12];

  initial begin
    int hlow, hfirst, hlast, hfa;
    int vlow, vfirst, vfa, fs_cnt;
    obs_t e;

    // Directed vectors on dut0, starting from a reset edge
    tbl[0]  = mkv(0, 1, 0, 0, 1, 1, 1, 0);
    tbl[1]  = mkv(1, 1, 0, 0, 1, 1, 1, 1);
    tbl[2]  = mkv(1, 0, 1, 0, 1, 1, 1, 0);
    tbl[3]  = mkv(1, 1, 1, 0, 1, 1, 1, 0);
    tbl[4]  = mkv(1, 0, 2, 0, 1, 1, 1, 0);
    tbl[5]  = mkv(1, 1, 2, 0, 1, 1, 1, 0);
    tbl[6]  = mkv(0, 0, 3, 0, 1, 1, 1, 0);
    tbl[7]  = mkv(1, 0, 0, 0, 1, 1, 1, 0);
    tbl[8]  = mkv(1, 1, 0, 0, 1, 1, 1, 1);
    tbl[9]  = mkv(1, 1, 1, 0, 1, 1, 1, 0);
    tbl[10] = mkv(0, 1, 2, 0, 1, 1, 1, 0);
    tbl[11] = mkv(1, 1, 0, 0, 1, 1, 1, 1);

    rst_n = 1'b0;
    ce    = 1'b0;
    cyc(0, 1);
    model_on = 1'b1;

    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].r, tbl[i].c);
      e.x = tbl[i].x; e.y = tbl[i].y; e.fa = tbl[i].fa; e.hs = tbl[i].hs;
      e.vs = tbl[i].vs; e.fs = tbl[i].fs; e.fc = 10'd0;
      check($sformatf("vec%0d", i), act_obs(0), e);
      clk_edge();
    end

    // Free-running with ce held high: line/frame sweeps
    hlow = 0; hfirst = -1; hlast = -1; hfa = 0;
    vlow = 0; vfirst = -1; vfa = 0; fs_cnt = 0;
    cyc(0, 1);
    for (int t = 0; t <= 12600; t++) begin
      drive(1, 1);
      if (t == 1) check_int("x_after_first_edge", int'(xo[0]), 1);
      if (t == 800) begin
        check_int("x_at_800", int'(xo[0]), 0);
        check_int("y_at_800", int'(yo[0]), 1);
      end
      if (t < 800) begin
        if (!hso[0]) begin
          hlow++;
          if (hfirst < 0) hfirst = t;
          hlast = t;
        end
        if (fao[0]) hfa++;
      end
      if (t < 4200) begin
        if (!vso[1]) begin
          vlow++;
          if (vfirst < 0) vfirst = t;
        end
        if (fao[1]) vfa++;
      end
      if (t <= 4200 && fso[1]) fs_cnt++;
      if (t == 512 * 8) check_int("y_alias_line512", int'(yo[1]), 0);
      if (t == 524 * 8) check_int("y_alias_line524", int'(yo[1]), 12);
      if (t == 12600) check_int("frame_ctr_3_frames", int'(fco[1]), CTR_EN ? 3 : 0);
      clk_edge();
    end
    check_int("hsync_low_cycles", hlow, 96);
    check_int("hsync_first_x", hfirst, 656);
    check_int("hsync_last_x", hlast, 751);
    check_int("active_cycles_line0", hfa, 640);
    check_int("vsync_low_cycles", vlow, 16);
    check_int("vsync_first_cycle", vfirst, 490 * 8);
    check_int("active_cycles_frame", vfa, 480 * 4);
    check_int("frame_start_count", fs_cnt, 2);

    // Random ce with occasional reset, checked against the model
    cyc(0, 1);
    for (int t = 0; t < 3000; t++) begin
      bit r, c;
      r = ($urandom_range(0, 299) != 0);
      c = 1'($urandom_range(0, 1));
      cyc(r, c);
    end

    // Reset mid-line at x=300
    cyc(0, 1);
    for (int t = 0; t < 1100; t++) cyc(1, 1);
    drive(1, 1);
    check_int("pre_reset_x", int'(xo[0]), 300);
    check_int("pre_reset_y", int'(yo[0]), 1);
    clk_edge();
    cyc(0, 1);
    drive(1, 0);
    e.x = 10'd0; e.y = 9'd0; e.fa = 1'b1; e.hs = 1'b1; e.vs = 1'b1; e.fs = 1'b0; e.fc = 10'd0;
    check("post_reset_state", act_obs(0), e);
    clk_edge();

    // Frame counter wrap on the tiny raster (16 cycles per frame)
    cyc(0, 1);
    for (int t = 0; t <= 16376; t++) begin
      drive(1, 1);
      if (t == 40)    check_int("tiny_ctr_3", int'(fco[2]), CTR_EN ? 3 : 0);
      if (t == 16375) check_int("tiny_ctr_1023", int'(fco[2]), CTR_EN ? 1023 : 0);
      if (t == 16376) check_int("tiny_ctr_wrap", int'(fco[2]), 0);
      clk_edge();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Pixel-timing generator for the 640x480 @ 60 Hz demo output. It produces the raster coordinates, the frame-active qualifier and the negative-polarity sync pulses that feed the graphics engine and the output pins. The block runs on the pixel clock domain with an optional clock enable for a 2x system clock, and it is the single source of raster position in the design.

## Interface
Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)

Ports:
- clk  in  1  pixel clock (25.175 MHz nominal), or 2x pixel clock used with ce
- rst_n  in  1  reset; synchronous, active-low
- ce  in  1  pixel advance enable; tie high when clk is the pixel clock
- x  out  10  horizontal counter, 0..799
- y  out  9  vertical counter truncated to 9 bits
- frame_active  out  1  high when x < H_ACTIVE and line < V_ACTIVE
- hsync  out  1  horizontal sync, active low
- vsync  out  1  vertical sync, active low
- frame_start  out  1  one-cycle pulse while at (0,0) and ce=1
- frame_ctr  out  10  frame count (see Configuration)

## Operation
- Internal h_cnt[9:0] and v_cnt[9:0]. H_TOTAL = 800, V_TOTAL = 525, both derived from the parameters.
- When ce=1: h_cnt increments. At H_TOTAL-1 it wraps to 0 and v_cnt advances. v_cnt wraps V_TOTAL-1 -> 0 on the same edge that h_cnt wraps from 799.
- When ce=0 all state holds, including the outputs and frame_start (which is gated low).
- x = h_cnt. y = v_cnt[8:0]. For lines 512..524, y aliases to 0..12; consumers must qualify y with frame_active.
- hsync is low for h_cnt in 656..751.
- vsync is low for v_cnt in 490..491 across all h positions.
- frame_active = (h_cnt < 640) && (v_cnt < 480).
- Reset (rst_n=0 at a clk edge, regardless of ce) gives h_cnt=0, v_cnt=0, so x=0, y=0, frame_active=1, hsync=1, vsync=1, frame_start=0, frame_ctr=0.
- Reset takes effect immediately and mid-frame; there is no drain and no partial-line completion.
- ce is ignored while rst_n=0.

## Timing
- hsync, vsync and frame_active are registers loaded from the next-state counter values. They change on the same edge as x/y and are never combinational decodes, so vsync is glitch-free (downstream uses it as a clock).
- Latency from coordinate to qualifier is zero: at any cycle, all outputs describe the same pixel.
- Line period is 800 ce-cycles and frame period is 420000 ce-cycles.
- frame_start is high for exactly the one ce-qualified cycle at which x=0 and v_cnt=0. It is also high in the first ce cycle after reset release.
- No handshake; the outputs are free-running.

## Configuration
- Macro VGA_TIMING_FRAME_CTR_EN.
- Defined: frame_ctr is a 10-bit register that increments on the ce edge where vsync goes 1 -> 0 (h_cnt 799 -> 0, v_cnt 489 -> 490). It wraps 1023 -> 0 and resets to 0.
- Undefined: no register is built and frame_ctr is tied to 10'd0. The port list is identical in both builds.

## Structure
- Shared package vga_timing_pkg holds:
  - the default timing constants;
  - derived H_TOTAL / V_TOTAL;
  - sync start/end localparams (H_SYNC_START = H_ACTIVE + H_FP, etc.).
- One sub-module, wrap_counter: a parameterised up-counter with enable, synchronous reset, max value and a wrap-out flag. It is instantiated for h (enable = ce) and for v (enable = ce & h_wrap).

## Test plan
- Reset release with ce=1 held: first edge gives x=1, y=0. After 800 cycles x=0, y=1. frame_start is seen once at cycle 0 and again at cycle 420000.
- Horizontal sweep on line 0: hsync=0 exactly for x 656..751 (96 cycles). frame_active=1 for x 0..639 and 0 for 640..799.
- Vertical sweep: vsync=0 exactly for lines 490 and 491 (1600 cycles). frame_active=0 for lines 480..524. y reads 0..12 on lines 512..524.
- ce toggled 1,0,1,0 from reset: x advances by one every two clocks. Outputs are stable in ce=0 cycles, and frame_start is never high when ce=0.
- Reset asserted at (x=300, y=200) for one cycle: next observed state is x=0, y=0, hsync=1, vsync=1, frame_active=1, frame_ctr=0.
- VGA_TIMING_FRAME_CTR_EN defined: after 3 full frames frame_ctr=3, and it increments on the vsync falling edge only. Force-advance of 1024 frames wraps it to 0. Undefined build: frame_ctr is constant 0.
